// File: rtl/ama_riscv_fetch_pkg.sv
// Shared definitions for the AMA-RISCV IF stage: next-PC select encodings
// (common with the decoder), the canonical NOP, IF FSM states and the
// next-PC helper.
package ama_riscv_fetch_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    PC_SEL_INC4       = 2'd0,
    PC_SEL_ALU        = 2'd1,
    PC_SEL_BP         = 2'd2,
    PC_SEL_START_ADDR = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    IF_RST   = 2'd0,
    IF_BOOT  = 2'd1,
    IF_RUN   = 2'd2,
    IF_STALL = 2'd3
  } if_state_e;

  // Next fetch PC. The ALU target is a JALR-style target, so bit 0 is
  // dropped. A set bit 1 is passed through; the misaligned-target exception
  // is raised further down the pipe.
  function automatic logic [31:0] next_pc(
    input pc_sel_e     sel,
    input logic [31:0] pc,
    input logic [31:0] alu_out,
    input logic [31:0] bp_target,
    input logic [31:0] reset_vector
  );
    logic [31:0] npc;
    unique case (sel)
      PC_SEL_INC4:       npc = pc + 32'd4;
      PC_SEL_ALU:        npc = {alu_out[31:1], 1'b0};
      PC_SEL_BP:         npc = bp_target;
      PC_SEL_START_ADDR: npc = reset_vector;
      default:           npc = pc;
    endcase
    return npc;
  endfunction

endpackage

// File: rtl/ama_riscv_if_hold_buf.sv
// IF/ID hold buffer: keeps the instruction that was on inst_id when a stall
// began, so it survives the cycles in which IMEM is not being read.
// Priority: clear > capture > release.
module ama_riscv_if_hold_buf
  import ama_riscv_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_i,
  input  logic        release_i,
  input  logic        clear_i,
  input  logic [31:0] data_i,
  output logic [31:0] hold_o,
  output logic        hold_vld_o
);

  logic [31:0] hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;

  // Next-state of the hold register and its valid flag.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (clear_i) begin
      hold_d     = NOP_INST;
      hold_vld_d = 1'b0;
    end else if (capture_i) begin
      hold_d     = data_i;
      hold_vld_d = 1'b1;
    end else if (release_i) begin
      hold_vld_d = 1'b0;
    end
  end

  // Hold register state.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the hold register is a single word of flops, not a memory, so
      // it is reset to NOP to keep inst_id defined straight out of reset.
      hold_q     <= NOP_INST;
      hold_vld_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end

  assign hold_o     = hold_q;
  assign hold_vld_o = hold_vld_q;

endmodule

// File: rtl/ama_riscv_fetch.sv
// AMA-RISCV IF stage: owns the PC, drives the synchronous IMEM port, aligns
// the one-cycle IMEM read data with its PC and presents inst_id/pc_id to
// the decoder, holding across stalls and injecting NOPs on flush.
// Optional build macro FETCH_PERF_CNT_EN adds the cnt_fetch/cnt_stall
// performance counters.
module ama_riscv_fetch
  import ama_riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          IMEM_AW      = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         pc_sel,
  input  logic               pc_we,
  input  logic               imem_en,
  input  logic               stall_if,
  input  logic               clear_if,
  input  logic [31:0]        alu_out,
  input  logic [31:0]        bp_target,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_req,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pc,
  output logic [31:0]        pc_id,
  output logic [31:0]        inst_id
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        cnt_fetch,
  output logic [31:0]        cnt_stall
`endif
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic        rdata_vld_q;   // a request was issued last cycle
  logic        clear_q;       // flush requested last cycle
  logic        pc_update;
  logic        hold_capture, hold_release;
  logic [31:0] hold_inst;
  logic        hold_vld;

  // IMEM port; nothing is fetched while held in reset state or stalled.
  assign imem_req  = imem_en & ~stall_if & (state_q != IF_RST);
  assign imem_addr = pc_q[IMEM_AW+1:2];

  // The PC only moves when it has actually been presented to IMEM.
  assign pc_update = pc_we & imem_req;

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IF_RST:   state_d = IF_BOOT;
      IF_BOOT:  state_d = IF_RUN;
      IF_RUN:   if (stall_if && !clear_if) state_d = IF_STALL;
      IF_STALL: if (!stall_if) state_d = IF_RUN;
      default:  state_d = IF_RST;
    endcase
  end

  // Next PC and the PC travelling with the fetched instruction.
  always_comb begin
    pc_d    = pc_q;
    pc_id_d = pc_id_q;
    if (pc_update) pc_d = next_pc(pc_sel_e'(pc_sel), pc_q, alu_out, bp_target, RESET_VECTOR);
    if (imem_req)  pc_id_d = pc_q;
  end

  // Pipeline registers of the IF stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IF_RST;
      pc_q        <= RESET_VECTOR;
      pc_id_q     <= RESET_VECTOR;
      rdata_vld_q <= 1'b0;
      clear_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_id_q     <= pc_id_d;
      rdata_vld_q <= imem_req;
      clear_q     <= clear_if;
    end
  end

  // Capture only on the first stall cycle; a flush in the same cycle wins.
  assign hold_capture = (state_q == IF_RUN) & stall_if & ~clear_if;
  assign hold_release = (state_q == IF_STALL) & ~stall_if;

  // The word captured is what the decoder is looking at right now, which is
  // the IMEM read data whenever a fetch was outstanding.
  ama_riscv_if_hold_buf u_hold_buf (
    .clk        (clk),
    .rst        (rst),
    .capture_i  (hold_capture),
    .release_i  (hold_release),
    .clear_i    (clear_if),
    .data_i     (inst_id),
    .hold_o     (hold_inst),
    .hold_vld_o (hold_vld)
  );

  // inst_id select: flush, then held word, then fresh IMEM data, else bubble.
  always_comb begin
    inst_id = NOP_INST;
    if (clear_q)          inst_id = NOP_INST;
    else if (hold_vld)    inst_id = hold_inst;
    else if (rdata_vld_q) inst_id = imem_rdata;
  end

  assign pc    = pc_q;
  assign pc_id = pc_id_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt_fetch_q, cnt_fetch_d;
  logic [31:0] cnt_stall_q, cnt_stall_d;

  assign cnt_fetch_d = cnt_fetch_q + {31'd0, imem_req};
  assign cnt_stall_d = cnt_stall_q + {31'd0, (state_q == IF_STALL)};

  // Free-running fetch and stall cycle counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_fetch_q <= 32'd0;
      cnt_stall_q <= 32'd0;
    end else begin
      cnt_fetch_q <= cnt_fetch_d;
      cnt_stall_q <= cnt_stall_d;
    end
  end

  assign cnt_fetch = cnt_fetch_q;
  assign cnt_stall = cnt_stall_q;
`endif

endmodule

// File: tb/tb_ama_riscv_fetch.sv
// Self-checking bench for ama_riscv_fetch: table of per-cycle stimulus with
// hand-computed expected outputs, plus a short hand-written stall/flush
// sequence. Also exercises cnt_fetch/cnt_stall when FETCH_PERF_CNT_EN is set.
module tb_ama_riscv_fetch;
  import ama_riscv_fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        rst;
    logic [1:0]  sel;
    logic        we;
    logic        en;
    logic        stall;
    logic        clear;
    logic [31:0] alu;
    logic [31:0] bp;
    logic [31:0] e_pc;
    logic [31:0] e_pcid;
    logic [31:0] e_inst;
    logic        e_req;
    logic        e_stl;   // FSM is in STALL during this cycle
  } vec_t;

  logic        clk;
  logic        rst;
  logic [1:0]  pc_sel;
  logic        pc_we, imem_en, stall_if, clear_if;
  logic [31:0] alu_out, bp_target;
  logic [13:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic [31:0] pc, pc_id, inst_id;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt_fetch, cnt_stall;
  int unsigned m_fetch;
  int unsigned m_stall;
`endif

  int n_checks;
  int n_errors;

  ama_riscv_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .pc_sel     (pc_sel),
    .pc_we      (pc_we),
    .imem_en    (imem_en),
    .stall_if   (stall_if),
    .clear_if   (clear_if),
    .alu_out    (alu_out),
    .bp_target  (bp_target),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .pc_id      (pc_id),
    .inst_id    (inst_id)
`ifdef FETCH_PERF_CNT_EN
    ,
    .cnt_fetch  (cnt_fetch),
    .cnt_stall  (cnt_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Preloaded IMEM contents: word 3 is the instruction used for the stall test.
  function automatic logic [31:0] mem_word(input logic [13:0] a);
    if (a == 14'd3) return 32'h0020_8133;
    return 32'hA000_0000 + {18'd0, a};
  endfunction

  // Synchronous IMEM model, one-cycle read latency.
  initial imem_rdata = 32'h0;
  always @(posedge clk) if (imem_req) imem_rdata <= mem_word(imem_addr);

  function automatic vec_t mk(
    input logic rst_v, input logic [1:0] sel, input logic we, input logic en,
    input logic stall, input logic clear, input logic [31:0] alu, input logic [31:0] bp,
    input logic [31:0] e_pc, input logic [31:0] e_pcid, input logic [31:0] e_inst,
    input logic e_req, input logic e_stl);
    vec_t v;
    v.rst = rst_v; v.sel = sel; v.we = we; v.en = en; v.stall = stall; v.clear = clear;
    v.alu = alu; v.bp = bp; v.e_pc = e_pc; v.e_pcid = e_pcid; v.e_inst = e_inst;
    v.e_req = e_req; v.e_stl = e_stl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then compare outputs.
  task automatic run_vec(input string tag, input vec_t v);
    logic [31:0] pcv;
    @(negedge clk);
    rst = v.rst; pc_sel = v.sel; pc_we = v.we; imem_en = v.en;
    stall_if = v.stall; clear_if = v.clear; alu_out = v.alu; bp_target = v.bp;
    #1;
    pcv = v.e_pc;
    check({tag, " pc"},        pc,                v.e_pc);
    check({tag, " pc_id"},     pc_id,             v.e_pcid);
    check({tag, " inst_id"},   inst_id,           v.e_inst);
    check({tag, " imem_req"},  {31'd0, imem_req}, {31'd0, v.e_req});
    check({tag, " imem_addr"}, {18'd0, imem_addr}, {18'd0, pcv[15:2]});
`ifdef FETCH_PERF_CNT_EN
    check({tag, " cnt_fetch"}, cnt_fetch, m_fetch);
    check({tag, " cnt_stall"}, cnt_stall, m_stall);
    if (v.rst) begin
      m_fetch = 0;
      m_stall = 0;
    end else begin
      m_fetch += v.e_req;
      m_stall += v.e_stl;
    end
`endif
  endtask

  vec_t vecs[26];

  initial begin
    n_checks = 0;
    n_errors = 0;
`ifdef FETCH_PERF_CNT_EN
    m_fetch = 0;
    m_stall = 0;
`endif
    rst = 1'b1; pc_sel = PC_SEL_INC4; pc_we = 1'b1; imem_en = 1'b1;
    stall_if = 1'b0; clear_if = 1'b0; alu_out = 32'h0; bp_target = 32'h0;

    //            rst sel                we en st cl alu           bp            pc            pc_id         inst          req stl
    vecs[0]  = mk(1, PC_SEL_INC4,       1, 1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        NOP,          0, 0);
    vecs[1]  = mk(0, PC_SEL_INC4,       1, 1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        NOP,          0, 0);
    vecs[2]  = mk(0, PC_SEL_INC4,       1, 1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        NOP,          1, 0);
    vecs[3]  = mk(0, PC_SEL_INC4,       1, 1, 0, 0, 32'h0,        32'h0,        32'h4,        32'h0,        32'hA000_0000, 1, 0);
    vecs[4]  = mk(0, PC_SEL_INC4,       1, 1, 0, 0, 32'h0,        32'h0,        32'h8,        32'h4,        32'hA000_0001, 1, 0);
    vecs[5]  = mk(0, PC_SEL_INC4,       1, 1, 0, 0, 32'h0,        32'h0,        32'hC,        32'h8,        32'hA000_0002, 1, 0);
    vecs[6]  = mk(0, PC_SEL_INC4,       1, 1, 1, 0, 32'h0,        32'h0,        32'h10,       32'hC,        32'h0020_8133, 0, 0);
    vecs[7]  = mk(0, PC_SEL_INC4,       1, 1, 1, 0, 32'h0,        32'h0,        32'h10,       32'hC,        32'h0020_8133, 0, 1);
    vecs[8]  = mk(0, PC_SEL_INC4,       1, 1, 1, 0, 32'h0,        32'h0,        32'h10,       32'hC,        32'h0020_8133, 0, 1);
    vecs[9]  = mk(0, PC_SEL_INC4,       1, 1, 0, 0, 32'h0,        32'h0,        32'h10,       32'hC,        32'h0020_8133, 1, 1);
    vecs[10] = mk(0, PC_SEL_ALU,        1, 1, 0, 1, 32'h101,      32'h0,        32'h14,       32'h10,       32'hA000_0004, 1, 0);
    vecs[11] = mk(0, PC_SEL_INC4,       1, 1, 0, 0, 32'h0,        32'h0,        32'h100,      32'h14,       NOP,          1, 0);
    vecs[12] = mk(0, PC_SEL_INC4,       1, 1, 1, 1, 32'h0,        32'h0,        32'h104,      32'h100,      32'hA000_0040, 0, 0);
    vecs[13] = mk(0, PC_SEL_INC4,       1, 1, 0, 0, 32'h0,        32'h0,        32'h104,      32'h100,      NOP,          1, 0);
    vecs[14] = mk(0, PC_SEL_BP,         1, 1, 0, 0, 32'h0,        32'h202,      32'h108,      32'h104,      32'hA000_0041, 1, 0);
    vecs[15] = mk(0, PC_SEL_BP,         1, 1, 0, 0, 32'h0,        32'hFFFF_FFFC, 32'h202,     32'h108,      32'hA000_0042, 1, 0);
    vecs[16] = mk(0, PC_SEL_INC4,       1, 1, 0, 0, 32'h0,        32'h0,        32'hFFFF_FFFC, 32'h202,     32'hA000_0080, 1, 0);
    vecs[17] = mk(0, PC_SEL_INC4,       1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'hFFFF_FFFC, 32'hA000_3FFF, 0, 0);
    vecs[18] = mk(0, PC_SEL_INC4,       0, 1, 0, 0, 32'h0,        32'h0,        32'h0,        32'hFFFF_FFFC, NOP,          1, 0);
    vecs[19] = mk(0, PC_SEL_ALU,        1, 1, 0, 0, 32'h11,       32'h0,        32'h0,        32'h0,        32'hA000_0000, 1, 0);
    vecs[20] = mk(0, PC_SEL_START_ADDR, 1, 1, 0, 0, 32'h0,        32'h0,        32'h10,       32'h0,        32'hA000_0000, 1, 0);
    vecs[21] = mk(0, PC_SEL_INC4,       1, 1, 1, 0, 32'h0,        32'h0,        32'h0,        32'h10,       32'hA000_0004, 0, 0);
    vecs[22] = mk(1, PC_SEL_INC4,       1, 1, 1, 0, 32'h0,        32'h0,        32'h0,        32'h10,       32'hA000_0004, 0, 1);
    vecs[23] = mk(0, PC_SEL_INC4,       1, 1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        NOP,          0, 0);
    vecs[24] = mk(0, PC_SEL_INC4,       1, 1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        NOP,          1, 0);
    vecs[25] = mk(0, PC_SEL_INC4,       1, 1, 0, 0, 32'h0,        32'h0,        32'h4,        32'h0,        32'hA000_0000, 1, 0);

    for (int i = 0; i < 26; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Flush arriving while already in STALL: the held word is dropped and a
    // NOP is presented on release, then fetching resumes at the frozen PC.
    run_vec("h0", mk(0, PC_SEL_INC4, 1, 1, 1, 0, 32'h0, 32'h0, 32'h8, 32'h4, 32'hA000_0001, 0, 0));
    run_vec("h1", mk(0, PC_SEL_INC4, 1, 1, 1, 1, 32'h0, 32'h0, 32'h8, 32'h4, 32'hA000_0001, 0, 1));
    run_vec("h2", mk(0, PC_SEL_INC4, 1, 1, 0, 0, 32'h0, 32'h0, 32'h8, 32'h4, NOP,          1, 1));
    run_vec("h3", mk(0, PC_SEL_INC4, 1, 1, 0, 0, 32'h0, 32'h0, 32'hC, 32'h8, 32'hA000_0002, 1, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
